// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder / program loader.
package instr_enc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CLSW = 3;

  typedef enum logic [CLSW-1:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_RTYPE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_ITYPE  = 3'd4,
    CLS_JAL    = 3'd5
  } op_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  typedef struct packed {
    logic [CLSW-1:0] cls;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
  } field_bundle_t;

  // Signed window test on a two's-complement immediate.
  function automatic logic imm_fits(input logic [XLEN-1:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and instruction-memory write channel of the encoder.
interface instr_encoder_if
  import instr_enc_pkg::*;
#(
  parameter int unsigned AW = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [CLSW-1:0] in_class;
  logic [RW-1:0]   in_rd;
  logic [RW-1:0]   in_rs1;
  logic [RW-1:0]   in_rs2;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [XLEN-1:0] in_imm;

  logic            imem_we;
  logic            imem_ready;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    output imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    input  imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_encoder_rv_field_pack.sv
// Combinational RV32I field packer: builds the instruction word and flags unencodable immediates.
module rv_field_pack
  import instr_enc_pkg::*;
(
  input  field_bundle_t   fields_i,
  output logic [XLEN-1:0] word_c_o,
  output logic            imm_ok_c_o
);

  logic [XLEN-1:0] imm;
  logic            i_ok;
  logic            b_ok;
  logic            j_ok;

  assign imm  = fields_i.imm;
  assign i_ok = imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
  // Branch and jump offsets are in bytes but must be halfword aligned.
  assign b_ok = imm_fits(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
  assign j_ok = imm_fits(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];

  always_comb begin
    word_c_o   = '0;
    imm_ok_c_o = 1'b0;
    case (fields_i.cls)
      CLS_LOAD: begin
        word_c_o   = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OP_LOAD};
        imm_ok_c_o = i_ok;
      end
      CLS_ITYPE: begin
        word_c_o   = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OP_ITYPE};
        imm_ok_c_o = i_ok;
      end
      CLS_STORE: begin
        word_c_o   = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], OP_STORE};
        imm_ok_c_o = i_ok;
      end
      CLS_RTYPE: begin
        word_c_o   = {1'b0, fields_i.funct7b5, 5'b00000, fields_i.rs2, fields_i.rs1,
                      fields_i.funct3, fields_i.rd, OP_RTYPE};
        imm_ok_c_o = 1'b1;
      end
      CLS_BRANCH: begin
        word_c_o   = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                      imm[4:1], imm[11], OP_BRANCH};
        imm_ok_c_o = b_ok;
      end
      CLS_JAL: begin
        word_c_o   = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, OP_JAL};
        imm_ok_c_o = j_ok;
      end
      default: begin
        word_c_o   = '0;
        imm_ok_c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field bundles, encodes them and writes them sequentially to imem.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic                       finish,
  instr_encoder_if.slave             bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] word_cnt
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  enc_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            busy_q, done_q;

  field_bundle_t   fields;
  logic [XLEN-1:0] enc_word_c;
  logic            enc_ok_c;
  logic [CW:0]     in_flight;
  logic            in_ready_c;
  logic            accept;
  logic            wr_done;

  assign fields = '{cls:      bus.in_class,
                    rd:       bus.in_rd,
                    rs1:      bus.in_rs1,
                    rs2:      bus.in_rs2,
                    funct3:   bus.in_funct3,
                    funct7b5: bus.in_funct7b5,
                    imm:      bus.in_imm};

  rv_field_pack u_pack (
    .fields_i   (fields),
    .word_c_o   (enc_word_c),
    .imm_ok_c_o (enc_ok_c)
  );

  // Words already written plus the one sitting in the output stage.
  assign in_flight  = {1'b0, cnt_q} + (CW+1)'(we_q);
  assign in_ready_c = (state_q == ST_RUN) && (!we_q || bus.imem_ready) && (in_flight < DEPTH_W);
  assign accept     = bus.in_valid && in_ready_c;
  assign wr_done    = we_q && bus.imem_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    if (wr_done) begin
      we_d   = 1'b0;
      addr_d = addr_q + AW'(4);
      cnt_d  = cnt_q + CW'(1);
    end

    // A completing write and a new accept may share a cycle: the new word reuses the stage.
    if (accept) begin
      if (enc_ok_c) begin
        we_d    = 1'b1;
        wdata_d = enc_word_c;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = {base_addr[AW-1:2], 2'b00};
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (finish || (in_flight == DEPTH_W)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!we_q || bus.imem_ready) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign word_cnt       = cnt_q;

endmodule
